// File: rtl/aoa_capture_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : aoa_capture_sequencer
//  Description : Runs one angle-of-arrival measurement at a time. Arms,
//                collects the first TDC code on each of the four channels
//                inside a bounded window, and holds those codes on the lookup
//                path until its result settles. Resolved angles are handed
//                downstream on a valid/ready handshake. Unresolved results
//                are counted and dropped. A holdoff period follows every
//                measurement before the sequencer re-arms.
//  Revision    : 1.0 - initial release
// ============================================================================
module aoa_capture_sequencer #(
    parameter int WINDOW_CYCLES  = 64,
    parameter int LUT_LATENCY    = 2,
    parameter int HOLDOFF_CYCLES = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        enable,
    input  logic [3:0]  hit_valid,
    input  logic [27:0] hit_code,
    output logic [6:0]  code_x1,
    output logic [6:0]  code_x2,
    output logic [6:0]  code_y1,
    output logic [6:0]  code_y2,
    input  logic [8:0]  lut_theta,
    output logic [8:0]  theta_out,
    output logic        theta_valid,
    input  logic        theta_ready,
    output logic        busy,
    output logic [7:0]  miss_count
);

    // State encoding
    localparam logic [2:0] c_st_idle    = 3'd0;
    localparam logic [2:0] c_st_armed   = 3'd1;
    localparam logic [2:0] c_st_capture = 3'd2;
    localparam logic [2:0] c_st_lookup  = 3'd3;
    localparam logic [2:0] c_st_output  = 3'd4;
    localparam logic [2:0] c_st_holdoff = 3'd5;

    // A single counter serves the window, the lookup wait and the holdoff,
    // so it is sized for the largest of the three.
    localparam int c_cnt_max =
        (WINDOW_CYCLES >= LUT_LATENCY && WINDOW_CYCLES >= HOLDOFF_CYCLES) ? WINDOW_CYCLES :
        (LUT_LATENCY >= HOLDOFF_CYCLES) ? LUT_LATENCY : HOLDOFF_CYCLES;
    localparam int c_cw = $clog2(c_cnt_max + 1);

    // The counter holds the number of window cycles already elapsed
    // (the first-hit cycle counts as one), so the last window cycle is
    // the one where it reads WINDOW_CYCLES-1.
    localparam logic [c_cw-1:0] c_win_last  = c_cw'(WINDOW_CYCLES - 1);
    localparam logic [c_cw-1:0] c_lut_last  = c_cw'(LUT_LATENCY);
    localparam logic [c_cw-1:0] c_hold_last = c_cw'(HOLDOFF_CYCLES - 1);
    localparam logic [c_cw-1:0] c_cnt_one   = c_cw'(1);

    localparam logic [6:0] c_no_hit    = 7'h7F;
    localparam logic [8:0] c_theta_max = 9'd360;

    logic [2:0]       r_state;
    logic [3:0][6:0]  r_code;
    logic [3:0]       r_cap;
    logic [c_cw-1:0]  r_cnt;

    logic [3:0][6:0]  w_hit_code;
    logic [3:0]       w_cap_next;
    logic             w_all_captured;
    logic             w_lut_bad;

    // The hit code bus already has the channel order of r_code.
    assign w_hit_code     = hit_code;
    assign w_cap_next     = r_cap | hit_valid;
    assign w_all_captured = &w_cap_next;
    // 9'h1FF and any out-of-range angle are both "unresolved".
    assign w_lut_bad      = (lut_theta > c_theta_max);

    assign code_x1 = r_code[0];
    assign code_x2 = r_code[1];
    assign code_y1 = r_code[2];
    assign code_y2 = r_code[3];

    assign busy = (r_state != c_st_idle) && (r_state != c_st_armed);

    // Measurement sequencer: capture, lookup wait, output handshake, holdoff.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= c_st_idle;
            r_code      <= {4{c_no_hit}};
            r_cap       <= '0;
            r_cnt       <= '0;
            theta_out   <= '0;
            theta_valid <= 1'b0;
            miss_count  <= '0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    r_code <= {4{c_no_hit}};
                    r_cap  <= '0;
                    r_cnt  <= '0;
                    if (enable) begin
                        r_state <= c_st_armed;
                    end
                end

                c_st_armed: begin
                    if (!enable) begin
                        r_state <= c_st_idle;
                    end else if (|hit_valid) begin
                        for (int ch = 0; ch < 4; ch++) begin
                            r_code[ch] <= hit_valid[ch] ? w_hit_code[ch] : c_no_hit;
                        end
                        r_cap <= hit_valid;
                        if (&hit_valid) begin
                            r_state <= c_st_lookup;
                            r_cnt   <= '0;
                        end else begin
                            r_state <= c_st_capture;
                            r_cnt   <= c_cnt_one;
                        end
                    end
                end

                c_st_capture: begin
                    // First hit per channel wins; later hits are ignored.
                    for (int ch = 0; ch < 4; ch++) begin
                        if (hit_valid[ch] && !r_cap[ch]) begin
                            r_code[ch] <= w_hit_code[ch];
                        end
                    end
                    r_cap <= w_cap_next;
                    if (w_all_captured || (r_cnt == c_win_last)) begin
                        r_state <= c_st_lookup;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + c_cnt_one;
                    end
                end

                c_st_lookup: begin
                    if (r_cnt == c_lut_last) begin
                        r_cnt <= '0;
                        if (w_lut_bad) begin
                            if (miss_count != 8'hFF) begin
                                miss_count <= miss_count + 8'd1;
                            end
                            r_code  <= {4{c_no_hit}};
                            r_cap   <= '0;
                            r_state <= c_st_holdoff;
                        end else begin
                            theta_out   <= lut_theta;
                            theta_valid <= 1'b1;
                            r_state     <= c_st_output;
                        end
                    end else begin
                        r_cnt <= r_cnt + c_cnt_one;
                    end
                end

                c_st_output: begin
                    if (theta_valid && theta_ready) begin
                        theta_valid <= 1'b0;
                        r_code      <= {4{c_no_hit}};
                        r_cap       <= '0;
                        r_cnt       <= '0;
                        r_state     <= c_st_holdoff;
                    end
                end

                c_st_holdoff: begin
                    if (r_cnt == c_hold_last) begin
                        r_cnt   <= '0;
                        r_state <= enable ? c_st_armed : c_st_idle;
                    end else begin
                        r_cnt <= r_cnt + c_cnt_one;
                    end
                end

                default: begin
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_aoa_capture_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_aoa_capture_sequencer
//  Description : Self-checking bench for aoa_capture_sequencer. A table of
//                measurement records drives hit patterns and a stub lookup
//                pipeline; hand-written sequences cover backpressure, enable
//                drop, miss saturation and reset in LOOKUP/OUTPUT.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_aoa_capture_sequencer;

    logic        clock;
    logic        reset;
    logic        enable;
    logic [3:0]  hit_valid;
    logic [27:0] hit_code;
    logic [6:0]  code_x1, code_x2, code_y1, code_y2;
    logic [8:0]  lut_theta;
    logic [8:0]  theta_out;
    logic        theta_valid;
    logic        theta_ready;
    logic        busy;
    logic [7:0]  miss_count;

    aoa_capture_sequencer #(
        .WINDOW_CYCLES (64),
        .LUT_LATENCY   (2),
        .HOLDOFF_CYCLES(16)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .enable     (enable),
        .hit_valid  (hit_valid),
        .hit_code   (hit_code),
        .code_x1    (code_x1),
        .code_x2    (code_x2),
        .code_y1    (code_y1),
        .code_y2    (code_y2),
        .lut_theta  (lut_theta),
        .theta_out  (theta_out),
        .theta_valid(theta_valid),
        .theta_ready(theta_ready),
        .busy       (busy),
        .miss_count (miss_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Stub lookup path: two register stages; returns stub_val only when the
    // presented codes equal stub_codes, otherwise 9'h1FF.
    logic [27:0] stub_codes;
    logic [8:0]  stub_val;
    logic [8:0]  lut_p1, lut_p2;
    always @(posedge clock) begin
        if (reset) begin
            lut_p1 <= 9'h1FF;
            lut_p2 <= 9'h1FF;
        end else begin
            lut_p1 <= ({code_y2, code_y1, code_x2, code_x1} == stub_codes) ? stub_val : 9'h1FF;
            lut_p2 <= lut_p1;
        end
    end
    assign lut_theta = lut_p2;

    typedef struct packed {
        logic [3:0]      mask;       // channels that hit
        logic [3:0][7:0] off;        // hit cycle per channel, relative to first hit
        logic [3:0][6:0] code;       // hit code per channel
        logic [7:0]      rep_off;    // second x1 hit cycle, 8'hFF = none
        logic [6:0]      rep_code;
        logic [8:0]      stub;       // stub lookup answer for the right codes
        logic [3:0][6:0] exp_code;   // {y2,y1,x2,x1} expected at LOOKUP entry
        logic [7:0]      exp_lookup; // edge index (first hit = 0) entering LOOKUP
        logic            exp_valid;
    } vec_t;

    localparam int N_VEC = 7;
    vec_t vecs [N_VEC];

    int n_pass;
    int n_total;
    int exp_miss;

    function automatic vec_t mk(input logic [3:0] mask, input logic [31:0] off,
                                input logic [27:0] code, input logic [7:0] rep_off,
                                input logic [6:0] rep_code, input logic [8:0] stub,
                                input logic [27:0] exp_code, input logic [7:0] exp_lookup,
                                input logic exp_valid);
        vec_t v;
        v.mask = mask; v.off = off; v.code = code;
        v.rep_off = rep_off; v.rep_code = rep_code; v.stub = stub;
        v.exp_code = exp_code; v.exp_lookup = exp_lookup; v.exp_valid = exp_valid;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [27:0] codes();
        return {code_y2, code_y1, code_x2, code_x1};
    endfunction

    task automatic drive_vec(input vec_t v, input int k);
        hit_valid = '0;
        hit_code  = '0;
        for (int c = 0; c < 4; c++) begin
            if (v.mask[c] && v.off[c] == 8'(k)) begin
                hit_valid[c]        = 1'b1;
                hit_code[c*7 +: 7]  = v.code[c];
            end
        end
        if (v.rep_off == 8'(k)) begin
            hit_valid[0]  = 1'b1;
            hit_code[6:0] = v.rep_code;
        end
    endtask

    task automatic wait_valid(input string name, input int bound);
        int n;
        n = 0;
        while (!theta_valid && n < bound) begin
            tick();
            n++;
        end
        chk(name, {31'd0, theta_valid}, 32'd1);
    endtask

    // Holdoff has just been entered: 15 more edges still busy, the 16th re-arms.
    task automatic check_holdoff(input string name);
        chk({name, " codes idle"}, {4'd0, codes()}, {4'd0, {4{7'h7F}}});
        repeat (15) tick();
        chk({name, " busy in holdoff"}, {31'd0, busy}, 32'd1);
        tick();
        chk({name, " rearmed"}, {31'd0, busy}, 32'd0);
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        logic early;
        int   last;
        early = 1'b0;
        last  = int'(v.exp_lookup) + 3;
        stub_codes = v.exp_code;
        stub_val   = v.stub;
        for (int k = 0; k <= last; k++) begin
            drive_vec(v, k);
            tick();
            if (k == int'(v.exp_lookup)) begin
                chk($sformatf("v%0d codes", idx), {4'd0, codes()}, {4'd0, v.exp_code});
            end
            if (k < last && theta_valid) early = 1'b1;
        end
        hit_valid = '0;
        hit_code  = '0;
        chk($sformatf("v%0d early valid", idx), {31'd0, early}, 32'd0);
        chk($sformatf("v%0d valid", idx), {31'd0, theta_valid}, {31'd0, v.exp_valid});
        if (v.exp_valid) begin
            chk($sformatf("v%0d theta", idx), {23'd0, theta_out}, {23'd0, v.stub});
            chk($sformatf("v%0d miss", idx), {24'd0, miss_count}, 32'(exp_miss));
            theta_ready = 1'b1;
            tick();
            theta_ready = 1'b0;
            chk($sformatf("v%0d accepted", idx), {31'd0, theta_valid}, 32'd0);
        end else begin
            if (exp_miss < 255) exp_miss++;
            chk($sformatf("v%0d miss", idx), {24'd0, miss_count}, 32'(exp_miss));
        end
        check_holdoff($sformatf("v%0d", idx));
    endtask

    initial begin
        logic stable, seen_valid, timed_out;
        int   n;

        n_pass = 0; n_total = 0; exp_miss = 0;
        reset = 1'b1; enable = 1'b0; hit_valid = '0; hit_code = '0;
        theta_ready = 1'b0; stub_codes = '0; stub_val = '0;

        // {y2,y1,x2,x1} ordering in every concatenation below
        vecs[0] = mk(4'hF, {8'd3, 8'd9, 8'd6, 8'd0}, {7'd20, 7'd30, 7'd5, 7'd10}, 8'hFF, 7'd0,
                     9'd45, {7'd20, 7'd30, 7'd5, 7'd10}, 8'd9, 1'b1);
        vecs[1] = mk(4'h1, {8'd0, 8'd0, 8'd0, 8'd0}, {7'd0, 7'd0, 7'd0, 7'd33}, 8'hFF, 7'd0,
                     9'd0, {7'h7F, 7'h7F, 7'h7F, 7'd33}, 8'd63, 1'b1);
        vecs[2] = mk(4'hF, {8'd0, 8'd0, 8'd0, 8'd0}, {7'd4, 7'd3, 7'd2, 7'd1}, 8'hFF, 7'd0,
                     9'd360, {7'd4, 7'd3, 7'd2, 7'd1}, 8'd0, 1'b1);
        vecs[3] = mk(4'h7, {8'd0, 8'd64, 8'd63, 8'd0}, {7'd0, 7'd11, 7'd9, 7'd7}, 8'hFF, 7'd0,
                     9'd200, {7'h7F, 7'h7F, 7'd9, 7'd7}, 8'd63, 1'b1);
        vecs[4] = mk(4'hF, {8'd2, 8'd0, 8'd2, 8'd0}, {7'd80, 7'd60, 7'd70, 7'd50}, 8'hFF, 7'd0,
                     9'd361, {7'd80, 7'd60, 7'd70, 7'd50}, 8'd2, 1'b0);
        vecs[5] = mk(4'hF, {8'd4, 8'd4, 8'd4, 8'd0}, {7'd23, 7'd22, 7'd21, 7'd12}, 8'd2, 7'd40,
                     9'd123, {7'd23, 7'd22, 7'd21, 7'd12}, 8'd4, 1'b1);
        vecs[6] = mk(4'h9, {8'd5, 8'd0, 8'd0, 8'd0}, {7'd99, 7'd0, 7'd0, 7'd0}, 8'hFF, 7'd0,
                     9'h1FF, {7'd99, 7'h7F, 7'h7F, 7'd0}, 8'd63, 1'b0);

        // Reset state
        repeat (2) tick();
        chk("reset codes", {4'd0, codes()}, {4'd0, {4{7'h7F}}});
        chk("reset theta_out", {23'd0, theta_out}, 32'd0);
        chk("reset theta_valid", {31'd0, theta_valid}, 32'd0);
        chk("reset miss_count", {24'd0, miss_count}, 32'd0);
        chk("reset busy", {31'd0, busy}, 32'd0);
        reset = 1'b0; enable = 1'b1;
        tick();
        chk("armed not busy", {31'd0, busy}, 32'd0);

        for (int i = 0; i < N_VEC; i++) begin
            run_vec(i, vecs[i]);
        end

        // Backpressure: ready low for 20 cycles, hit burst must be ignored.
        stub_codes = {7'd14, 7'd13, 7'd12, 7'd11};
        stub_val   = 9'd90;
        hit_valid  = 4'hF; hit_code = {7'd14, 7'd13, 7'd12, 7'd11};
        tick();
        hit_valid  = '0; hit_code = '0;
        wait_valid("hold valid rise", 10);
        stable = 1'b1;
        for (int i = 0; i < 20; i++) begin
            hit_valid = (i == 5 || i == 6) ? 4'hF : 4'h0;
            hit_code  = {4{7'd1}};
            tick();
            if (!theta_valid || theta_out != 9'd90 || codes() != {7'd14, 7'd13, 7'd12, 7'd11})
                stable = 1'b0;
        end
        hit_valid = '0;
        chk("hold stable", {31'd0, stable}, 32'd1);
        theta_ready = 1'b1;
        tick();
        theta_ready = 1'b0;
        chk("hold accepted", {31'd0, theta_valid}, 32'd0);
        for (int h = 1; h <= 16; h++) begin
            hit_valid = (h == 10 || h == 16) ? 4'hF : 4'h0;
            tick();
        end
        hit_valid = '0;
        chk("holdoff hits ignored", {31'd0, busy}, 32'd0);
        tick();
        chk("holdoff hits not queued", {31'd0, busy}, 32'd0);

        // Enable dropped mid-measurement: completes, then parks in IDLE.
        stub_codes = {4{7'd2}};
        stub_val   = 9'd55;
        hit_valid  = 4'hF; hit_code = {4{7'd2}};
        tick();
        hit_valid  = '0; enable = 1'b0;
        wait_valid("enable drop valid", 10);
        chk("enable drop theta", {23'd0, theta_out}, 32'd55);
        theta_ready = 1'b1;
        tick();
        theta_ready = 1'b0;
        repeat (16) tick();
        chk("enable drop done", {31'd0, busy}, 32'd0);
        enable = 1'b1; hit_valid = 4'hF;
        tick();
        hit_valid = '0;
        chk("enable drop idle", {31'd0, busy}, 32'd0);

        // Miss saturation: 300 unresolved measurements.
        stub_codes = '0;
        hit_code   = {4{7'd1}};
        seen_valid = 1'b0; timed_out = 1'b0;
        for (int i = 0; i < 300; i++) begin
            hit_valid = 4'hF;
            tick();
            hit_valid = '0;
            n = 0;
            while (busy && n < 30) begin
                tick();
                if (theta_valid) seen_valid = 1'b1;
                n++;
            end
            if (busy) timed_out = 1'b1;
        end
        chk("sat no timeout", {31'd0, timed_out}, 32'd0);
        chk("sat no valid", {31'd0, seen_valid}, 32'd0);
        chk("sat miss_count", {24'd0, miss_count}, 32'd255);

        // Reset during LOOKUP.
        stub_codes = {4{7'd3}}; stub_val = 9'd77;
        hit_valid = 4'hF; hit_code = {4{7'd3}};
        tick();
        hit_valid = '0;
        tick();
        reset = 1'b1;
        tick();
        chk("rst lookup codes", {4'd0, codes()}, {4'd0, {4{7'h7F}}});
        chk("rst lookup busy", {31'd0, busy}, 32'd0);
        chk("rst lookup miss", {24'd0, miss_count}, 32'd0);
        chk("rst lookup theta_out", {23'd0, theta_out}, 32'd0);
        reset = 1'b0; hit_valid = 4'hF;
        tick();
        hit_valid = '0;
        chk("rst lookup idle", {31'd0, busy}, 32'd0);

        // Reset during OUTPUT with a pending theta_valid.
        hit_valid = 4'hF;
        tick();
        hit_valid = '0;
        wait_valid("rst output valid", 10);
        chk("rst output theta", {23'd0, theta_out}, 32'd77);
        reset = 1'b1;
        tick();
        chk("rst output valid clr", {31'd0, theta_valid}, 32'd0);
        chk("rst output theta clr", {23'd0, theta_out}, 32'd0);
        chk("rst output busy", {31'd0, busy}, 32'd0);
        chk("rst output codes", {4'd0, codes()}, {4'd0, {4{7'h7F}}});
        reset = 1'b0; hit_valid = 4'hF;
        tick();
        hit_valid = '0;
        chk("rst output idle", {31'd0, busy}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/aoa_capture_sequencer.md
Name: aoa_capture_sequencer

Overview:
Sequences one angle-of-arrival measurement through the 4-channel TDC-code-to-theta lookup datapath.
- Arms and waits for the first sensor hit, then collects the first code per channel (x1, x2, y1, y2) within a bounded window.
- Drives the collected codes to the lookup path and holds them stable through its pipeline latency.
- Samples the resulting 9-bit theta and hands valid angles downstream on a valid/ready handshake; invalid results are counted and dropped.
- Sits between the TDC front-end and the angle consumer (display/UART packer).

Parameters:
WINDOW_CYCLES, 64, capture window length in clocks, counted from the first-hit cycle inclusive (>=2).
LUT_LATENCY, 2, clock edges from code presentation to valid lut_theta (>=1).
HOLDOFF_CYCLES, 16, dead time after each measurement before re-arming (>=1).

Ports:
clock  in  1  system clock; all logic on the rising edge.
reset  in  1  synchronous, active-high reset.
enable  in  1  allow arming of new measurements.
hit_valid  in  4  per-channel hit strobe; bit0=x1, bit1=x2, bit2=y1, bit3=y2.
hit_code  in  28  per-channel TDC code, 7 bits each; [6:0]=x1, [13:7]=x2, [20:14]=y1, [27:21]=y2.
code_x1, code_x2, code_y1, code_y2  out  7 each  registered codes to the lookup datapath; 7'h7F = no hit.
lut_theta  in  9  theta from the lookup datapath; 9'h1FF = unresolved.
theta_out  out  9  captured angle, 0..360.
theta_valid  out  1  theta_out is valid; held until accepted.
theta_ready  in  1  downstream accept.
busy  out  1  high in every state except IDLE and ARMED.
miss_count  out  8  count of unresolved measurements; saturates at 255.

Behaviour:
- Reset values: all code_* = 7'h7F; theta_out = 0; theta_valid = 0; miss_count = 0; state = IDLE; counters = 0.
- States: IDLE, ARMED, CAPTURE, LOOKUP, OUTPUT, HOLDOFF.
- IDLE:
  - codes forced to 7'h7F.
  - enable=1 -> ARMED on the next edge.
- ARMED:
  - enable=0 -> IDLE.
  - Otherwise, on any hit_valid bit: latch the code of every asserted channel, clear all captured flags except those channels, window counter = 1, -> CAPTURE.
  - If all four bits are set in the arming cycle -> LOOKUP directly.
- CAPTURE:
  - Per channel, only the first hit is latched; later hits on a captured channel are ignored.
  - Hits in the same cycle on different channels are all latched.
  - Exit to LOOKUP when all four channels are captured, or when the window counter reaches WINDOW_CYCLES; hits in that final cycle are still latched.
  - Uncaptured channels remain 7'h7F.
- LOOKUP:
  - code_* held constant.
  - Wait counter starts at 0 on entry; lut_theta is sampled on the edge where the counter equals LUT_LATENCY, i.e. LUT_LATENCY+1 cycles after entry, which gives margin for the registered stage plus the combinational output.
  - lut_theta == 9'h1FF: miss_count += 1 (saturating at 255), -> HOLDOFF; no output.
  - lut_theta >= 361 (other than 9'h1FF): treated identically to 9'h1FF.
  - Otherwise: theta_out <= lut_theta, theta_valid <= 1, -> OUTPUT.
- OUTPUT:
  - theta_valid and theta_out stay stable until theta_valid && theta_ready is seen at an edge.
  - On that edge: theta_valid <= 0, -> HOLDOFF.
  - theta_ready while not valid has no effect.
- HOLDOFF:
  - codes reset to 7'h7F on entry; counter runs HOLDOFF_CYCLES cycles.
  - Then -> ARMED if enable=1, else IDLE.
- Hits outside ARMED and CAPTURE are ignored and are not queued.
- Deasserting enable after ARMED does not abort: the measurement completes and then returns to IDLE.
- Reset asserted in any state returns all registers to their reset values on the next edge, including clearing a pending theta_valid. miss_count is cleared only by reset.
- busy = (state != IDLE && state != ARMED).

Test Plan:
1. Hits arrive 3 cycles apart: x1 code 10, then y2 code 20, then x2 code 5, then y1 code 30. Stub lut_theta = 45 when codes match -> all four codes presented, lookup stage reached in cycle 10 after the first hit, theta_out = 45 with theta_valid; theta_ready accepted one cycle later; rearmed after 16 holdoff cycles.
2. Only x1 hits (code 33); window expires -> code_x1 = 33, others = 7'h7F; LOOKUP entered after exactly 64 cycles from the hit; stub returns 0 -> theta_out = 0.
3. Stub returns 9'h1FF -> no theta_valid pulse; miss_count increments from 0 to 1. Repeat 300 times -> miss_count = 255.
4. theta_ready held low for 20 cycles -> theta_valid and theta_out stable throughout. A second hit burst during this time is ignored, and the next measurement starts only after holdoff.
5. Repeat hit on x1 (codes 12 then 40) within the window -> code_x1 = 12. All four channels hit in the same cycle as arming -> LOOKUP on the next edge.
6. Reset pulsed during LOOKUP, and separately during OUTPUT with theta_valid=1 -> all outputs return to reset values on the next edge; state IDLE; busy = 0.
